// File: rtl/clock_set_ctrl.sv
// Mode/time-set controller: debounces MODE/ADV, sequences RUN->SET_HOUR->SET_MIN->SET_SEC, gates TICK,
// issues auto-repeating step pulses and a blink mask; button press to registered outputs in DEB_CYCLES+3 edges.
module clock_set_ctrl #(
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 8,
  parameter int BLINK_HALF   = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       BTN_MODE,
  input  logic       BTN_ADV,
  input  logic       DEC,
  output logic       RUN_EN,
  output logic       STEP_HOUR,
  output logic       STEP_MIN,
  output logic       SEC_CLR,
  output logic       STEP_DN,
  output logic [2:0] BLANK,
  output logic [1:0] MODE
);

  localparam int CW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
  localparam int BW   = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HOUR = 2'b01,
    S_MIN  = 2'b10,
    S_SEC  = 2'b11
  } state_t;

  // Button index 0 is MODE, index 1 is ADV.
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    deb_prev_q, deb_prev_d;
  logic [CW-1:0] deb_cnt_q [2];
  logic [CW-1:0] deb_cnt_d [2];

  state_t        state_q, state_d;
  logic          rep_act_q, rep_act_d;
  logic          rep_first_q, rep_first_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  logic          run_en_q, run_en_d;
  logic          step_hour_q, step_hour_d;
  logic          step_min_q, step_min_d;
  logic          sec_clr_q, sec_clr_d;
  logic          step_dn_q, step_dn_d;
  logic [2:0]    blank_q, blank_d;

  logic          mode_press;
  logic          adv_press;
  logic          step_fire;

  always_comb begin
    sync1_d    = {BTN_ADV, BTN_MODE};
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end

    mode_press = deb_q[0] & ~deb_prev_q[0];
    adv_press  = deb_q[1] & ~deb_prev_q[1] & ~mode_press;

    state_d     = state_q;
    rep_act_d   = rep_act_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
    step_fire   = 1'b0;
    sec_clr_d   = 1'b0;

    if (mode_press) begin
      rep_act_d = 1'b0;
      case (state_q)
        S_RUN:   state_d = S_HOUR;
        S_HOUR:  state_d = S_MIN;
        S_MIN:   state_d = S_SEC;
        default: state_d = S_RUN;
      endcase
    end else begin
      case (state_q)
        S_HOUR, S_MIN: begin
          if (adv_press) begin
            step_fire   = 1'b1;
            rep_act_d   = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
          end else if (rep_act_q) begin
            if (!deb_q[1]) begin
              rep_act_d = 1'b0;
            end else if (rep_cnt_q == (rep_first_q ? RW'(REPEAT_DELAY - 1)
                                                   : RW'(REPEAT_RATE - 1))) begin
              step_fire   = 1'b1;
              rep_first_d = 1'b0;
              rep_cnt_d   = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
        end
        S_SEC:   sec_clr_d = adv_press;
        default: ;
      endcase
    end

    step_hour_d = step_fire && (state_q == S_HOUR);
    step_min_d  = step_fire && (state_q == S_MIN);
    step_dn_d   = step_fire ? DEC : step_dn_q;
    run_en_d    = TICK && (state_d == S_RUN);

    // Restarting the blink on any adjustment keeps the field visible while the user edits it.
    if ((state_d != state_q) || step_fire || sec_clr_d || (state_d == S_RUN)) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
    end

    case (state_d)
      S_HOUR:  blank_d = {phase_d, 2'b00};
      S_MIN:   blank_d = {1'b0, phase_d, 1'b0};
      S_SEC:   blank_d = {2'b00, phase_d};
      default: blank_d = 3'b000;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      deb_cnt_q   <= '{default: '0};
      state_q     <= S_RUN;
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      run_en_q    <= 1'b0;
      step_hour_q <= 1'b0;
      step_min_q  <= 1'b0;
      sec_clr_q   <= 1'b0;
      step_dn_q   <= 1'b0;
      blank_q     <= 3'b000;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      run_en_q    <= run_en_d;
      step_hour_q <= step_hour_d;
      step_min_q  <= step_min_d;
      sec_clr_q   <= sec_clr_d;
      step_dn_q   <= step_dn_d;
      blank_q     <= blank_d;
    end
  end

  assign RUN_EN    = run_en_q;
  assign STEP_HOUR = step_hour_q;
  assign STEP_MIN  = step_min_q;
  assign SEC_CLR   = sec_clr_q;
  assign STEP_DN   = step_dn_q;
  assign BLANK     = blank_q;
  assign MODE      = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random button/tick traffic against a cycle model.
module tb_clock_set_ctrl;
  localparam int P_DEB   = 4;
  localparam int P_DELAY = 16;
  localparam int P_RATE  = 8;
  localparam int P_BLINK = 32;

  logic       CLK = 1'b0;
  logic       RESET, TICK, BTN_MODE, BTN_ADV, DEC;
  logic       RUN_EN, STEP_HOUR, STEP_MIN, SEC_CLR, STEP_DN;
  logic [2:0] BLANK;
  logic [1:0] MODE;

  clock_set_ctrl #(
    .DEB_CYCLES(P_DEB), .REPEAT_DELAY(P_DELAY), .REPEAT_RATE(P_RATE), .BLINK_HALF(P_BLINK)
  ) dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .BTN_MODE(BTN_MODE), .BTN_ADV(BTN_ADV), .DEC(DEC),
    .RUN_EN(RUN_EN), .STEP_HOUR(STEP_HOUR), .STEP_MIN(STEP_MIN), .SEC_CLR(SEC_CLR),
    .STEP_DN(STEP_DN), .BLANK(BLANK), .MODE(MODE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state: raw-sample histories, debounced levels, cycle-stamped repeat/blink timing.
  int          n = 0;
  logic [15:0] mh = '0, ah = '0;
  bit          dm = 0, dmp = 0, da = 0, dap = 0;
  int          e_mode = 0;
  bit          e_run_en = 0, e_sh = 0, e_sm = 0, e_sc = 0, e_dn = 0;
  logic [2:0]  e_blank = '0;
  bit          rep_on = 0;
  int          rep_next = 0;
  int          blink_start = 0;

  function automatic bit settles(input logic [15:0] h, input bit lvl);
    for (int k = 1; k <= P_DEB; k++) if (h[k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit pm, pa, step, phase;
    int old_mode;
    n++;
    if (RESET) begin
      mh = '0; ah = '0; dm = 0; dmp = 0; da = 0; dap = 0;
      e_mode = 0; e_run_en = 0; e_sh = 0; e_sm = 0; e_sc = 0; e_dn = 0; e_blank = '0;
      rep_on = 0; blink_start = n;
      return;
    end
    pm = dm && !dmp;
    pa = da && !dap && !pm;
    old_mode = e_mode;
    step = 0; e_sc = 0;
    if (pm) begin
      e_mode = (e_mode + 1) % 4;
      rep_on = 0;
    end else if (old_mode == 1 || old_mode == 2) begin
      if (pa) begin
        step = 1; rep_on = 1; rep_next = n + P_DELAY;
      end else if (rep_on && !da) begin
        rep_on = 0;
      end else if (rep_on && n == rep_next) begin
        step = 1; rep_next = n + P_RATE;
      end
    end else if (old_mode == 3 && pa) begin
      e_sc = 1;
    end
    e_sh = step && old_mode == 1;
    e_sm = step && old_mode == 2;
    if (step) e_dn = DEC;
    if (e_mode != old_mode || step || e_sc || e_mode == 0) blink_start = n;
    phase = (((n - blink_start) / P_BLINK) % 2) == 1;
    case (e_mode)
      1:       e_blank = {phase, 2'b00};
      2:       e_blank = {1'b0, phase, 1'b0};
      3:       e_blank = {2'b00, phase};
      default: e_blank = 3'b000;
    endcase
    e_run_en = TICK && e_mode == 0;
    if (settles(mh, dm)) begin dmp = dm; dm = !dm; end else dmp = dm;
    if (settles(ah, da)) begin dap = da; da = !da; end else dap = da;
    mh = {mh[14:0], BTN_MODE};
    ah = {ah[14:0], BTN_ADV};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  int cnt_sh = 0, cnt_sm = 0, cnt_sc = 0, cnt_run = 0;

  task automatic cycle();
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
    chk("run_en", RUN_EN, e_run_en);
    chk("step_hour", STEP_HOUR, e_sh);
    chk("step_min", STEP_MIN, e_sm);
    chk("sec_clr", SEC_CLR, e_sc);
    chk("step_dn", STEP_DN, e_dn);
    chk("blank", BLANK, e_blank);
    chk("mode", MODE, e_mode);
    chk("onehot_steps", $onehot0({STEP_HOUR, STEP_MIN, SEC_CLR}), 1);
    cnt_sh  += STEP_HOUR;
    cnt_sm  += STEP_MIN;
    cnt_sc  += SEC_CLR;
    cnt_run += RUN_EN;
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  task automatic press_mode();
    BTN_MODE = 1; run(10);
    BTN_MODE = 0; run(10);
  endtask

  initial begin
    int times[$];
    int first;
    logic [2:0] prev;
    int changes;

    RESET = 1; TICK = 0; BTN_MODE = 0; BTN_ADV = 0; DEC = 0;

    // 1. Reset with TICK pulsing, then RUN_EN follows TICK by one cycle.
    for (int i = 0; i < 3; i++) begin TICK = (i % 2 == 0); cycle(); end
    chk("rst_outs", {RUN_EN, STEP_HOUR, STEP_MIN, SEC_CLR, STEP_DN, BLANK}, 0);
    chk("rst_mode", MODE, 0);
    RESET = 0; cnt_run = 0;
    for (int i = 0; i < 30; i++) begin TICK = (i % 10 == 0); cycle(); end
    TICK = 0;
    chk("run_en_count", cnt_run, 3);

    // 2. Short glitches ignored; a held press lands on edge 7.
    for (int len = 1; len <= 3; len++) begin
      BTN_MODE = 1; run(len);
      BTN_MODE = 0; run(10);
    end
    chk("glitch_mode", MODE, 0);
    first = 0; cnt_run = 0;
    BTN_MODE = 1;
    for (int i = 1; i <= 10; i++) begin
      TICK = (i == 8);
      cycle();
      if (MODE == 2'b01 && first == 0) first = i;
    end
    TICK = 0; BTN_MODE = 0; run(10);
    chk("mode_edge", first, 7);
    chk("set_run_en", cnt_run, 0);

    // 3. Auto-repeat in SET_HOUR with DEC=1.
    DEC = 1; BTN_ADV = 1; cnt_sh = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (STEP_HOUR) begin
        times.push_back(i);
        chk("rep_dn", STEP_DN, 1);
      end
    end
    chk("rep_count", times.size(), 4);
    if (times.size() == 4) begin
      chk("rep_t0", times[0], 7);
      chk("rep_gap1", times[1] - times[0], P_DELAY);
      chk("rep_gap2", times[2] - times[1], P_RATE);
      chk("rep_gap3", times[3] - times[2], P_RATE);
    end
    BTN_ADV = 0; DEC = 0; cnt_sh = 0;
    run(30);
    chk("rep_release", cnt_sh, 0);

    // 4. MODE wins over simultaneous ADV; SET_SEC gives one SEC_CLR.
    press_mode();
    cnt_sm = 0;
    BTN_MODE = 1; BTN_ADV = 1; run(10);
    BTN_MODE = 0; BTN_ADV = 0; run(10);
    chk("both_mode", MODE, 3);
    chk("both_nostep", cnt_sm, 0);
    cnt_sc = 0;
    BTN_ADV = 1; run(30);
    BTN_ADV = 0; run(10);
    chk("sec_clr_once", cnt_sc, 1);

    // 5. Idle blink in SET_MIN, then a step restarts the phase.
    press_mode(); press_mode(); press_mode();
    chk("in_set_min", MODE, 2);
    run(1);
    prev = BLANK; changes = 0;
    for (int i = 0; i < 96; i++) begin
      cycle();
      if (BLANK != prev) changes++;
      prev = BLANK;
    end
    chk("blink_toggles", changes, 3);
    run(20);
    BTN_ADV = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (STEP_MIN) chk("blank_on_step", BLANK, 0);
    end
    BTN_ADV = 0; run(15);

    // 6. Reset during auto-repeat, ADV still held afterwards.
    press_mode(); press_mode(); press_mode();
    chk("in_set_hour", MODE, 1);
    BTN_ADV = 1; run(25);
    RESET = 1; cycle();
    chk("mid_rst_mode", MODE, 0);
    chk("mid_rst_outs", {RUN_EN, STEP_HOUR, STEP_MIN, SEC_CLR, STEP_DN, BLANK}, 0);
    RESET = 0; cnt_sh = 0; cnt_sm = 0;
    run(40);
    chk("run_ignores_adv", cnt_sh + cnt_sm, 0);
    BTN_ADV = 0; run(10);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      TICK  = ($urandom_range(0, 9) == 0);
      DEC   = $urandom_range(0, 1);
      RESET = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 11) == 0) BTN_MODE = ~BTN_MODE;
      if ($urandom_range(0, 7) == 0)  BTN_ADV  = ~BTN_ADV;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
